rr_grant_arbiter: RTL and testbench

Four-requester round-robin arbiter that shares one downstream resource, such as a bus or register-file port, among requesters 0–3. It holds a registered 2-bit grant address and expands it through a 2-to-4 enable-gated decode into one-hot grant lines. It sits between the requesting blocks and the shared resource's select and enable inputs. Grants persist while the holder keeps requesting, and ownership rotates fairly on release.

---
 rtl/rr_grant_arbiter_if.sv | 26 ++
 rtl/rr_grant_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rr_grant_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between four requesters and rr_grant_arbiter.
// master = requester side, slave = arbiter side.
interface rr_grant_arbiter_if;
  logic       enable;
  logic       req0;
  logic       req1;
  logic       req2;
  logic       req3;
  logic       gnt0;
  logic       gnt1;
  logic       gnt2;
  logic       gnt3;
  logic       gnt_valid;
  logic [1:0] gnt_addr;
  logic       preempt;

  modport master (
    output enable, req0, req1, req2, req3,
    input  gnt0, gnt1, gnt2, gnt3, gnt_valid, gnt_addr, preempt
  );

  modport slave (
    input  enable, req0, req1, req2, req3,
    output gnt0, gnt1, gnt2, gnt3, gnt_valid, gnt_addr, preempt
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Four-requester round-robin arbiter with a registered grant address decoded to one-hot grants.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD hold counter with forced rotation and preempt pulse.
module rr_grant_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  rr_grant_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_addr;
  logic [1:0] w_addr_next;

  logic [3:0] w_req;
  logic [1:0] w_cand_idx [4];
  logic [3:0] w_cand_req;
  logic       w_other_found;
  logic [1:0] w_other_idx;
  logic       w_any_found;
  logic [1:0] w_any_idx;
  logic [3:0] w_gnt;
  logic       w_valid;

  // Out-of-range MAX_HOLD leaves this marker block in the elaborated hierarchy.
  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_out_of_range
  end

  assign w_req = {bus.req3, bus.req2, bus.req1, bus.req0};

  // Candidate gi sits gi+1 places after the pointer; candidate 3 is the pointer itself.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign w_cand_idx[gi] = r_addr + 2'(gi + 1);
      assign w_cand_req[gi] = w_req[w_cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    w_other_found = 1'b0;
    w_other_idx   = r_addr;
    for (int i = 2; i >= 0; i--) begin
      if (w_cand_req[i]) begin
        w_other_found = 1'b1;
        w_other_idx   = w_cand_idx[i];
      end
    end
    w_any_found = w_other_found | w_cand_req[3];
    w_any_idx   = w_other_found ? w_other_idx : r_addr;
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  logic [3:0] r_hold_cnt;
  logic [3:0] w_hold_cnt_next;
  logic       r_preempt;
  logic       w_preempt_next;
  logic       w_hold_expired;

  assign w_hold_expired = (r_hold_cnt == HOLD_LIMIT);
`endif

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
`ifdef ARB_TIMEOUT_EN
    w_hold_cnt_next = r_hold_cnt;
    w_preempt_next  = 1'b0;
`endif
    if (!bus.enable) begin
      w_state_next = IDLE;
`ifdef ARB_TIMEOUT_EN
      w_hold_cnt_next = 4'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_found) begin
            w_state_next = GRANT;
            w_addr_next  = w_any_idx;
`ifdef ARB_TIMEOUT_EN
            w_hold_cnt_next = 4'd0;
`endif
          end
        end
        GRANT: begin
          // Handoff never considers the releasing holder.
          if (!w_req[r_addr]) begin
            if (w_other_found) begin
              w_addr_next = w_other_idx;
            end else begin
              w_state_next = IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            w_hold_cnt_next = 4'd0;
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            if (w_hold_expired && w_other_found) begin
              w_addr_next     = w_other_idx;
              w_hold_cnt_next = 4'd0;
              w_preempt_next  = 1'b1;
            end else if (!w_hold_expired) begin
              w_hold_cnt_next = r_hold_cnt + 4'd1;
            end
`endif
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_addr  <= 2'b11;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hold_cnt <= 4'd0;
      r_preempt  <= 1'b0;
    end else begin
      r_hold_cnt <= w_hold_cnt_next;
      r_preempt  <= w_preempt_next;
    end
  end

  assign bus.preempt = r_preempt;
`else
  assign bus.preempt = 1'b0;
`endif

  assign w_valid = (r_state == GRANT);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_decode
      assign w_gnt[gi] = w_valid & (r_addr == 2'(gi));
    end
  endgenerate

  assign bus.gnt0      = w_gnt[0];
  assign bus.gnt1      = w_gnt[1];
  assign bus.gnt2      = w_gnt[2];
  assign bus.gnt3      = w_gnt[3];
  assign bus.gnt_valid = w_valid;
  assign bus.gnt_addr  = r_addr;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: directed steps push expected outputs, a monitor pops and checks.
// The ARB_TIMEOUT_EN build adds MAX_HOLD=4 rotation vectors.
module tb_rr_grant_arbiter;

  typedef struct {
    int         id;
    logic [3:0] gnt;
    logic [1:0] addr;
    logic       pre;
  } exp_t;

  logic clk;
  logic reset_n;
  exp_t sb[$];
  int   n_compared;
  int   n_mismatched;
  int   step_id;

  rr_grant_arbiter_if bus ();

  rr_grant_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs required after the next edge.
  task automatic step(input logic rst_n, input logic en, input logic [3:0] req,
                      input logic [3:0] gnt, input logic [1:0] addr, input logic pre);
    exp_t e;
    @(negedge clk);
    reset_n    = rst_n;
    bus.enable = en;
    {bus.req3, bus.req2, bus.req1, bus.req0} = req;
    e.id   = step_id;
    e.gnt  = gnt;
    e.addr = addr;
    e.pre  = pre;
    sb.push_back(e);
    step_id++;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [3:0] act_gnt;
    logic       exp_valid;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e         = sb.pop_front();
        act_gnt   = {bus.gnt3, bus.gnt2, bus.gnt1, bus.gnt0};
        exp_valid = |e.gnt;
        n_compared++;
        if (act_gnt !== e.gnt || bus.gnt_valid !== exp_valid ||
            bus.gnt_addr !== e.addr || bus.preempt !== e.pre) begin
          n_mismatched++;
          $display("FAIL step%0d grant_outputs: got gnt=%b valid=%b addr=%0d preempt=%b, required gnt=%b valid=%b addr=%0d preempt=%b",
                   e.id, act_gnt, bus.gnt_valid, bus.gnt_addr, bus.preempt,
                   e.gnt, exp_valid, e.addr, e.pre);
        end else begin
          $display("step%0d ok: gnt=%b valid=%b addr=%0d preempt=%b",
                   e.id, act_gnt, bus.gnt_valid, bus.gnt_addr, bus.preempt);
        end
      end
    end
  end

  initial begin : stimulus
    int waited;
    n_compared   = 0;
    n_mismatched = 0;
    step_id      = 0;
    reset_n      = 1'b0;
    bus.enable   = 1'b0;
    {bus.req3, bus.req2, bus.req1, bus.req0} = 4'b0000;

    // Reset, with reset overriding enable and requests.
    step(0, 0, 4'b0000, 4'b0000, 2'd3, 0);
    step(0, 1, 4'b1111, 4'b0000, 2'd3, 0);

    // All requesting, each holder releases after two cycles: 0,1,2,3,0.
    step(1, 1, 4'b1111, 4'b0001, 2'd0, 0);
    step(1, 1, 4'b1111, 4'b0001, 2'd0, 0);
    step(1, 1, 4'b1110, 4'b0010, 2'd1, 0);
    step(1, 1, 4'b1110, 4'b0010, 2'd1, 0);
    step(1, 1, 4'b1101, 4'b0100, 2'd2, 0);
    step(1, 1, 4'b1101, 4'b0100, 2'd2, 0);
    step(1, 1, 4'b1011, 4'b1000, 2'd3, 0);
    step(1, 1, 4'b1011, 4'b1000, 2'd3, 0);
    step(1, 1, 4'b0111, 4'b0001, 2'd0, 0);
    step(1, 1, 4'b0111, 4'b0001, 2'd0, 0);
    step(1, 1, 4'b0000, 4'b0000, 2'd0, 0);

    // Single req2 pulse of three cycles; address retained afterwards.
    step(1, 1, 4'b0100, 4'b0100, 2'd2, 0);
    step(1, 1, 4'b0100, 4'b0100, 2'd2, 0);
    step(1, 1, 4'b0100, 4'b0100, 2'd2, 0);
    step(1, 1, 4'b0000, 4'b0000, 2'd2, 0);
    step(1, 1, 4'b0000, 4'b0000, 2'd2, 0);

    // Holder 1 releases with req3 pending, req1 returns: grant goes to 3.
    step(1, 1, 4'b0010, 4'b0010, 2'd1, 0);
    step(1, 1, 4'b1010, 4'b0010, 2'd1, 0);
    step(1, 1, 4'b1000, 4'b1000, 2'd3, 0);
    step(1, 1, 4'b1010, 4'b1000, 2'd3, 0);
    step(1, 1, 4'b0010, 4'b0010, 2'd1, 0);
    step(1, 1, 4'b0000, 4'b0000, 2'd1, 0);

    // Enable drop during gnt0 with req0/req2 high, then re-enable selects 2.
    step(1, 1, 4'b0001, 4'b0001, 2'd0, 0);
    step(1, 1, 4'b0101, 4'b0001, 2'd0, 0);
    step(1, 0, 4'b0101, 4'b0000, 2'd0, 0);
    step(1, 0, 4'b0101, 4'b0000, 2'd0, 0);
    step(1, 1, 4'b0101, 4'b0100, 2'd2, 0);
    step(1, 1, 4'b0000, 4'b0000, 2'd2, 0);

    // Reset during gnt3; next search starts at requester 0.
    step(1, 1, 4'b1000, 4'b1000, 2'd3, 0);
    step(0, 1, 4'b1001, 4'b0000, 2'd3, 0);
    step(1, 1, 4'b1001, 4'b0001, 2'd0, 0);
    step(1, 1, 4'b0000, 4'b0000, 2'd0, 0);

    // req0 and req1 held continuously from reset.
    step(0, 1, 4'b0000, 4'b0000, 2'd3, 0);
`ifdef ARB_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 5; k++) step(1, 1, 4'b0011, 4'b0001, 2'd0, (r > 0 && k == 0) ? 1'b1 : 1'b0);
      for (int k = 0; k < 5; k++) step(1, 1, 4'b0011, 4'b0010, 2'd1, (k == 0) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 5; k++) step(1, 1, 4'b0011, 4'b0001, 2'd0, (k == 0) ? 1'b1 : 1'b0);
`else
    for (int k = 0; k < 20; k++) step(1, 1, 4'b0011, 4'b0001, 2'd0, 0);
`endif
    // Only req0 held: grant never drops, no preempt.
    for (int k = 0; k < 20; k++) step(1, 1, 4'b0001, 4'b0001, 2'd0, 0);

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (sb.size() > 0) begin
      n_mismatched++;
      $display("FAIL drain_timeout: got %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
